// File: rtl/pmem_write_buffer.sv
// Eviction write buffer between the victim cache and physical memory: absorbs
// writebacks in one cycle, drains them in FIFO order when upstream is idle.
module pmem_write_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  // state   | meaning
  // S_IDLE  | accept upstream request, or start a drain when no request
  // S_RESP  | one-cycle completion pulse to upstream
  // S_PREAD | read miss forwarded to physical memory
  // S_DRAIN | head line being written to physical memory
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESP  = 2'd1;
  localparam logic [1:0] S_PREAD = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head_q, tail_q;
  logic [PW:0]           count_q;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          full, empty;
  logic          upd_en, push_en, pop_en;

  // Coalescing keeps at most one valid entry per address.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == mem_address)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    upd_en  = 1'b0;
    push_en = 1'b0;
    pop_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read) begin
          if (hit) begin
            rdata_d = data_q[hit_idx];
            state_d = S_RESP;
          end else begin
            state_d = S_PREAD;
          end
        end else if (mem_write) begin
          if (hit) begin
            upd_en  = 1'b1;
            state_d = S_RESP;
          end else if (!full) begin
            push_en = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (!empty) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP: state_d = S_IDLE;
      S_PREAD: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = S_RESP;
        end
      end
      S_DRAIN: begin
        if (pmem_resp) begin
          pop_en  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (push_en) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
        count_q         <= count_q + CNT_ONE;
      end else if (pop_en) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
        count_q         <= count_q - CNT_ONE;
      end
    end
  end

  // Line storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push_en) begin
      addr_q[tail_q] <= mem_address;
      data_q[tail_q] <= mem_wdata;
    end else if (upd_en) begin
      data_q[hit_idx] <= mem_wdata;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_resp   = (state_q == S_RESP);
  assign pmem_read  = (state_q == S_PREAD);
  assign pmem_write = (state_q == S_DRAIN);

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_q == S_PREAD) begin
      pmem_address = mem_address;
    end else if (state_q == S_DRAIN) begin
      pmem_address = addr_q[head_q];
      pmem_wdata   = data_q[head_q];
    end
  end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Bench for pmem_write_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pmem_write_buffer;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp;

  pmem_write_buffer #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the buffer is an ordered list of lines, the oldest first.
  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } ent_t;
  typedef enum {M_IDLE, M_ACK, M_FETCH, M_EVICT} mph_t;

  ent_t          bq[$];
  mph_t          mph = M_IDLE;
  logic [LW-1:0] m_rdata = '0;

  function automatic int find(input logic [AW-1:0] a);
    for (int i = 0; i < bq.size(); i++) if (bq[i].a == a) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int   k;
    ent_t e;
    if (rst) begin
      bq.delete();
      mph = M_IDLE;
      m_rdata = '0;
    end else begin
      case (mph)
        M_IDLE: begin
          k = find(mem_address);
          if (mem_read) begin
            if (k >= 0) begin m_rdata = bq[k].d; mph = M_ACK; end
            else mph = M_FETCH;
          end else if (mem_write) begin
            if (k >= 0) begin
              e = bq[k]; e.d = mem_wdata; bq[k] = e; mph = M_ACK;
            end else if (bq.size() < DEPTH) begin
              e.a = mem_address; e.d = mem_wdata; bq.push_back(e); mph = M_ACK;
            end else mph = M_EVICT;
          end else if (bq.size() != 0) mph = M_EVICT;
        end
        M_ACK: mph = M_IDLE;
        M_FETCH: if (pmem_resp) begin m_rdata = pmem_rdata; mph = M_ACK; end
        M_EVICT: if (pmem_resp) begin void'(bq.pop_front()); mph = M_IDLE; end
        default: mph = M_IDLE;
      endcase
    end
  end

  logic prev_resp = 1'b0;
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [LW-1:0] ed;
    if (chk_en) begin
      ea = '0;
      ed = '0;
      if (mph == M_FETCH) ea = mem_address;
      else if (mph == M_EVICT) begin ea = bq[0].a; ed = bq[0].d; end
      chk("mem_resp", mem_resp, mph == M_ACK);
      chk("pmem_read", pmem_read, mph == M_FETCH);
      chk("pmem_write", pmem_write, mph == M_EVICT);
      chk("pmem_address", pmem_address, ea);
      chk("pmem_wdata", pmem_wdata, ed);
      if (mph == M_ACK) chk("mem_rdata", mem_rdata, m_rdata);
      chk("pmem_rd_wr_exclusive", pmem_read && pmem_write, 0);
      chk("mem_resp_single_pulse", prev_resp && mem_resp, 0);
      prev_resp = mem_resp;
    end
  end

  // Physical memory responder: answers after pd cycles unless held.
  int            pd = 0;
  bit            hold = 1'b0;
  int            pcnt = 0;
  logic [LW-1:0] rd_val = '0;
  logic [AW-1:0] drained[$];
  int            drain_cyc[$];

  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && !hold && !rst) begin
        if (pcnt >= pd) begin
          pmem_resp = 1'b1;
          pmem_rdata = rd_val;
          pcnt = 0;
          if (pmem_write) begin
            drained.push_back(pmem_address);
            drain_cyc.push_back(cyc);
          end
        end else pcnt++;
      end else pcnt = 0;
    end
  end

  task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [LW-1:0] d, output int lat);
    int n;
    bit done;
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (mem_resp) done = 1'b1;
      else begin
        n++;
        if (n > 300) begin
          checks++; errors++;
          $display("FAIL req_timeout: no mem_resp for address %h after %0d cycles", a, n);
          done = 1'b1;
        end
      end
    end
    lat = n;
  endtask

  task automatic rel();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pw();
    int n = 0;
    while (!pmem_write && n < 50) begin @(posedge clk); #1; n++; end
    chk("wait_pmem_write", pmem_write, 1);
  endtask

  task automatic wait_drains(input int k);
    int n = 0;
    while (drained.size() < k && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_count", drained.size(), k);
    idle(2);
  endtask

  initial begin : director
    int            lat, rcyc, op;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [AW-1:0] exp_a [5];
    exp_a = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset: everything quiet.
    repeat (10) begin
      @(negedge clk);
      chk("idle_mem_resp", mem_resp, 0);
      chk("idle_pmem_read", pmem_read, 0);
      chk("idle_pmem_write", pmem_write, 0);
      chk("idle_pmem_address", pmem_address, 0);
      chk("idle_mem_rdata", mem_rdata, 0);
    end
    @(posedge clk); #1;

    // Single writeback, then its drain.
    hold = 1'b1;
    req(0, 1, 32'h1000, {64{4'hA}}, lat);
    chk("wr_latency", lat, 1);
    chk("wr_resp_no_pmem_write", pmem_write, 0);
    rel();
    @(negedge clk);
    chk("drain_not_yet", pmem_write, 0);
    @(negedge clk);
    chk("drain_pmem_write", pmem_write, 1);
    chk("drain_address", pmem_address, 32'h1000);
    chk("drain_wdata", pmem_wdata, {64{4'hA}});
    @(posedge clk); #1;
    pd = 3; hold = 1'b0;
    wait_drains(1);
    chk("drain1_addr", drained[0], 32'h1000);
    chk("count_after_drain", bq.size(), 0);

    // Read hit while the drain is stalled, then coalescing write.
    drained.delete(); drain_cyc.delete();
    hold = 1'b1;
    req(0, 1, 32'h1000, {64{4'h1}}, lat);
    rel();
    req(1, 0, 32'h1000, '0, lat);
    chk("hit_latency", lat, 1);
    chk("hit_rdata", mem_rdata, {64{4'h1}});
    rel();
    req(0, 1, 32'h1000, {64{4'h2}}, lat);
    chk("coalesce_latency", lat, 1);
    chk("coalesce_count", bq.size(), 1);
    rel();
    wait_pw();
    chk("coalesce_drain_addr", pmem_address, 32'h1000);
    chk("coalesce_drain_wdata", pmem_wdata, {64{4'h2}});
    pd = 1; hold = 1'b0;
    wait_drains(1);

    // Read miss forwarded to physical memory.
    drained.delete(); drain_cyc.delete();
    pd = 5; rd_val = {32{8'h5A}};
    req(1, 0, 32'h2000, '0, lat);
    chk("miss_latency", lat, 7);
    chk("miss_rdata", mem_rdata, {32{8'h5A}});
    chk("miss_pmem_read_dropped", pmem_read, 0);
    chk("miss_no_writes", drained.size(), 0);
    rel();

    // Fill the buffer, then a fifth write forces one drain.
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      req(0, 1, exp_a[k-1], {8{32'(k)}}, lat);
      rel();
    end
    chk("full_count", bq.size(), 4);
    fork
      begin
        req(0, 1, 32'h500, {8{32'h5}}, lat);
        rcyc = cyc;
      end
      begin
        wait_pw();
        chk("full_first_drain_addr", pmem_address, 32'h100);
        pd = 2; hold = 1'b0;
      end
    join
    chk("full_write_resp_delay", rcyc - drain_cyc[0], 2);
    rel();
    pd = 1;
    wait_drains(5);
    for (int i = 0; i < 5; i++) chk("drain_order", drained[i], exp_a[i]);

    // Reset in the middle of a drain drops the buffered line.
    drained.delete(); drain_cyc.delete();
    hold = 1'b1;
    req(0, 1, 32'h700, {32{8'h77}}, lat);
    rel();
    wait_pw();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_count", bq.size(), 0);
    @(posedge clk); #1;
    hold = 1'b0; pd = 2; rd_val = {32{8'h33}};
    req(1, 0, 32'h700, '0, lat);
    chk("post_rst_miss_latency", lat, 4);
    chk("post_rst_rdata", mem_rdata, {32{8'h33}});
    rel();
    chk("post_rst_no_writes", drained.size(), 0);

    // Randomized traffic over a small address pool.
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 19);
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      for (int w = 0; w < 8; w++) rd_val[w*32 +: 32] = $urandom;
      pd = $urandom_range(0, 3);
      a = 32'h100 * AW'($urandom_range(1, 6));
      if (op < 8) begin req(0, 1, a, d, lat); rel(); end
      else if (op < 14) begin req(1, 0, a, '0, lat); rel(); end
      else if (op == 14) begin req(1, 1, a, d, lat); rel(); end
      else if (op == 19 && (it % 4) == 0) begin
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      end else idle($urandom_range(1, 4));
    end
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
